// File: rtl/line_sensor_emu_pkg.sv
// line_sensor_emu_pkg: shared types and LFSR constants for the line sensor emulator.
package line_sensor_emu_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, READOUT} state_t;
  typedef enum logic [1:0] {PAT_RAMP, PAT_CONST, PAT_CHECKER, PAT_FRAME} pattern_t;
  typedef logic [11:0] pixel_t;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 as a bit mask over lfsr[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], ^(l & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/line_sensor_emulator_sync_edge_detect.sv
// sync_edge_detect: multi-flop synchronizer followed by a rising-edge pulse.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise
);
  logic [STAGES-1:0] sr;
  logic prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr <= '0;
      prev <= 1'b0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
      prev <= sr[STAGES-1];
    end
  assign level = sr[STAGES-1];
  assign rise = level & ~prev;
endmodule

// File: rtl/line_sensor_emulator.sv
// line_sensor_emulator: responder-side emulator of a linear image sensor (SI capture, delay, pixel readout).
// Define LINE_SENSOR_EMU_NOISE_EN to XOR LFSR noise into the low nibble of each pixel.
module line_sensor_emulator
  import line_sensor_emu_pkg::*;
#(
  parameter int NUMBER_OF_PIXEL = 128,
  parameter int DELAY_NCLK = 18,
  parameter int RAMP_STEP = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic        master_clock,
  input  logic        resetn,
  input  logic        sensor_clk,
  input  logic        sensor_si,
  input  logic [1:0]  pattern_sel,
  input  logic [11:0] const_value,
  output logic        emu_pclk,
  output logic        emu_sync,
  output logic [11:0] emu_data,
  output logic [9:0]  emu_index,
  output logic [15:0] frame_count,
  output logic        busy,
  output logic        overrun
);
  state_t state, state_n;
  pattern_t pat;
  pixel_t cval, fval, pat_val, px;
  logic [SYNC_STAGES-1:0] si_sr;
  logic [15:0] dcnt;
  logic [9:0] n;
  logic clk_s, clk_rise, si_s, si_prev, capture, pix, last;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_clk_sync (
    .clk(master_clock),
    .rst_n(resetn),
    .d(sensor_clk),
    .level(clk_s),
    .rise(clk_rise)
  );

  always_ff @(posedge master_clock or negedge resetn)
    if (!resetn) si_sr <= '0;
    else si_sr <= {si_sr[SYNC_STAGES-2:0], sensor_si};
  assign si_s = si_sr[SYNC_STAGES-1];

  // A new SI capture always wins over a pixel on the same sensor edge
  always_comb begin
    capture = clk_rise & si_s & ~si_prev;
    pix = clk_rise & ~capture & (state == READOUT);
    last = pix & (n == 10'(NUMBER_OF_PIXEL - 1));
    state_n = capture ? WAIT
            : (clk_rise && state == WAIT && dcnt == 16'(DELAY_NCLK - 1)) ? READOUT
            : last ? IDLE : state;
  end

  always_ff @(posedge master_clock or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_n;

  always_comb begin
    pat_val = pat == PAT_RAMP ? pixel_t'(22'(n) * 22'(RAMP_STEP))
            : pat == PAT_CONST ? cval
            : pat == PAT_CHECKER ? {12{n[0]}} : fval;
  end

`ifdef LINE_SENSOR_EMU_NOISE_EN
  logic [15:0] lfsr;
  always_ff @(posedge master_clock or negedge resetn)
    if (!resetn) lfsr <= LFSR_SEED;
    else if (pix) lfsr <= lfsr_next(lfsr);
  assign px = pat_val ^ {8'h00, lfsr[3:0]};
`else
  assign px = pat_val;
`endif

  always_ff @(posedge master_clock or negedge resetn)
    if (!resetn) begin
      si_prev <= 1'b0;
      dcnt <= '0;
      n <= '0;
      pat <= PAT_RAMP;
      cval <= '0;
      fval <= '0;
      emu_pclk <= 1'b0;
      emu_sync <= 1'b0;
      emu_data <= '0;
      emu_index <= '0;
      frame_count <= '0;
      busy <= 1'b0;
      overrun <= 1'b0;
    end else begin
      busy <= state_n != IDLE;
      if (clk_rise) si_prev <= si_s;
      if (capture) begin
        dcnt <= '0;
        n <= '0;
        pat <= pattern_t'(pattern_sel);
        cval <= const_value;
        fval <= frame_count[11:0];
        overrun <= overrun | (state != IDLE);
      end else if (clk_rise && state == WAIT) dcnt <= dcnt + 16'd1;
      emu_pclk <= pix;
      emu_sync <= pix && n == '0;
      if (pix) begin
        emu_index <= n;
        emu_data <= px;
        n <= n + 10'd1;
      end
      if (last) frame_count <= frame_count + 16'd1;
    end
endmodule

// File: doc/line_sensor_emulator.md
Name: line_sensor_emulator

Overview:
Synthesizable emulator of the 128-pixel linear image sensor, used for hardware-in-loop bring-up of the sensor driver without a real device. It is the responder end of the sensor interface. It oversamples the driver's sensor clock and start (SI) pulse on master_clock, runs the sensor's delay/readout sequence, and emits a pixel-clock strobe, a sync marker, pixel index and synthetic 12-bit pixel data. It sits in the test build in place of the sensor pins and feeds the driver's capture path.

Parameters:
NUMBER_OF_PIXEL, 128, pixels per frame (max 1024).
DELAY_NCLK, 18, sensor-clock rising edges ignored after SI capture, before pixel 0.
RAMP_STEP, 32, per-pixel increment in ramp pattern.
SYNC_STAGES, 2, synchronizer depth on sensor_clk and sensor_si (minimum 2).

Ports:
master_clock  in  1  system clock; all logic on its rising edge.
resetn  in  1  asynchronous, active-low reset.
sensor_clk  in  1  sensor clock from driver; asynchronous, oversampled.
sensor_si  in  1  start pulse from driver; asynchronous, oversampled.
pattern_sel  in  2  0 ramp, 1 constant, 2 checker, 3 frame count.
const_value  in  12  value for constant pattern.
emu_pclk  out  1  one-cycle strobe per pixel.
emu_sync  out  1  high with emu_pclk for pixel 0 only.
emu_data  out  12  pixel value; holds between strobes.
emu_index  out  10  pixel index of emu_data.
frame_count  out  16  completed frames; wraps.
busy  out  1  high in WAIT or READOUT.
overrun  out  1  sticky; SI arrived while busy.

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; synchronizers cleared.
- Input path: SYNC_STAGES-flop synchronizers, then one edge register. clk_rise = sync'd clk now 1, previous 0.
- SI capture: clk_rise while sync'd SI=1 and SI sampled at the previous clk_rise was 0. SI held high across several sensor clocks captures only once.
- On capture: latch pattern_sel and const_value for the whole frame. Clear the delay counter. Enter WAIT.
- WAIT: count clk_rise. After DELAY_NCLK edges, enter READOUT. The next clk_rise produces pixel 0.
- READOUT: each clk_rise produces one pixel. emu_pclk=1, emu_index=n and emu_data are all registered one master_clock cycle after the clk_rise cycle.
  - emu_sync=1 only when n=0.
  - After pixel NUMBER_OF_PIXEL-1: frame_count increments in the same cycle as that strobe, then IDLE.
- Capture while in WAIT or READOUT:
  - overrun is set.
  - The frame is aborted; frame_count does not increment.
  - The delay counter is cleared and the state re-enters WAIT.
  - Capture takes priority over a pixel on the same clk_rise; no strobe is issued.
- clk_rise outside WAIT/READOUT: ignored.
- Patterns (12-bit, truncating):
  - ramp = (n*RAMP_STEP) mod 4096.
  - constant = latched const_value.
  - checker = n[0] ? 12'hFFF : 12'h000.
  - frame count = frame_count[11:0] value at frame start.
- Multiply: n*RAMP_STEP computed in 22 bits, low 12 bits kept. An accumulator is acceptable if results are identical.
- busy = state != IDLE, registered.
- overrun clears only on reset.

Optional Feature:
- Macro LINE_SENSOR_EMU_NOISE_EN.
- Defined:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 at reset.
  - Advances once per emitted pixel.
  - Its low 4 bits are XORed into emu_data[3:0] after pattern generation.
- Undefined: no LFSR logic; emu_data is exactly the pattern.

Decomposition:
- Package line_sensor_emu_pkg holds:
  - state enum: IDLE, WAIT, READOUT.
  - pattern enum: PAT_RAMP, PAT_CONST, PAT_CHECKER, PAT_FRAME.
  - LFSR seed/taps constants.
  - 12-bit pixel typedef.
- Sub-module sync_edge_detect (synchronizer + rising-edge pulse), instantiated for sensor_clk. sensor_si uses synchronizer only.

Test Plan:
- Ramp frame, defaults: sensor clock period 200 master_clock cycles, SI high over one sensor edge.
  - Required: no strobe for 18 edges, then 128 strobes.
  - emu_sync only with index 0.
  - index 127 data = 4064 (12'hFE0).
  - frame_count 0→1; busy falls after last strobe.
- Constant pattern, const_value=12'h5A5: all 128 pixels 12'h5A5.
  - const_value changed to 12'h123 mid-frame: no effect until next frame.
- SI asserted at pixel 60:
  - overrun=1; no strobe on that edge.
  - frame_count unchanged.
  - new frame: 18 silent edges, then index 0 with emu_sync.
- resetn low at pixel 40: outputs 0 immediately, IDLE, and no strobes until a new SI capture.
- SI held high for 5 sensor clocks: exactly one capture; overrun stays 0.
- With LINE_SENSOR_EMU_NOISE_EN, constant 12'h000:
  - emu_data[11:4]=0.
  - low nibble matches the reference LFSR sequence from 16'hACE1.
  - Without the macro, all zeros.
